// File: rtl/popcount_accumulator.sv
// Streaming popcount reducer: popcounts each accepted word and emits one total per WORDS-word vector.
// Optional threshold compare (thresh / out_above) is enabled by defining POPCOUNT_ACC_THRESH_EN.

module popcount #(
  parameter int IN_SIZE  = 16,
  parameter int OUT_SIZE = 5
) (
  input  logic [IN_SIZE-1:0]  in_data,
  output logic [OUT_SIZE-1:0] count
);

  // NOTE: combinational outputs get a default before any conditional or loop update so no latch is inferred.
  always_comb begin
    count = '0;
    for (int i = 0; i < IN_SIZE; i++) begin
      count = count + OUT_SIZE'(in_data[i]);
    end
  end

endmodule

module popcount_accumulator #(
  parameter int IN_SIZE  = 16,
  parameter int OUT_SIZE = 5,
  parameter int WORDS    = 4,
  parameter int ACC_SIZE = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_SIZE-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_SIZE-1:0] out_count
`ifdef POPCOUNT_ACC_THRESH_EN
  ,
  input  logic [ACC_SIZE-1:0] thresh,
  output logic                out_above
`endif
);

  localparam logic [1:0] ACCUM  = 2'd0;
  localparam logic [1:0] FLUSH  = 2'd1;
  localparam logic [1:0] OUTPUT = 2'd2;

  localparam int              IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [IDX_W-1:0]    idx;
  logic                pc_v;
  logic                pc_last;
  logic [ACC_SIZE-1:0] pc_q;
  logic [ACC_SIZE-1:0] acc;
  logic [ACC_SIZE-1:0] sum;
  logic [ACC_SIZE-1:0] count_q;
  logic [OUT_SIZE-1:0] word_count;
  logic                accept;
  logic                last_word;
`ifdef POPCOUNT_ACC_THRESH_EN
  logic                above_q;
`endif

  popcount #(
    .IN_SIZE  (IN_SIZE),
    .OUT_SIZE (OUT_SIZE)
  ) u_popcount (
    .in_data (in_data),
    .count   (word_count)
  );

  // Handshake outputs are gated by rst so they read idle during the whole reset window.
  assign in_ready  = !rst && ((state == ACCUM) || ((state == OUTPUT) && out_ready));
  assign out_valid = !rst && (state == OUTPUT);
  assign out_count = rst ? '0 : count_q;
`ifdef POPCOUNT_ACC_THRESH_EN
  assign out_above = !rst && above_q;
`endif

  assign accept    = in_valid && in_ready;
  assign last_word = (idx == LAST_IDX);
  assign sum       = acc + pc_q;

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (accept && last_word) state_next = FLUSH;
      FLUSH:   state_next = OUTPUT;
      // With WORDS=1 the word taken on the handoff cycle completes a vector immediately.
      OUTPUT:  if (out_ready) state_next = (accept && last_word) ? FLUSH : ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // NOTE: all state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACCUM;
      idx     <= '0;
      pc_v    <= 1'b0;
      pc_last <= 1'b0;
      pc_q    <= '0;
      acc     <= '0;
      count_q <= '0;
`ifdef POPCOUNT_ACC_THRESH_EN
      above_q <= 1'b0;
`endif
    end else begin
      state <= state_next;
      pc_v  <= accept;
      if (accept) begin
        pc_q    <= ACC_SIZE'(word_count);
        pc_last <= last_word;
        idx     <= last_word ? '0 : idx + 1'b1;
      end
      if (pc_v) begin
        acc <= pc_last ? '0 : sum;
      end
      if (state == FLUSH) begin
        count_q <= sum;
`ifdef POPCOUNT_ACC_THRESH_EN
        above_q <= (sum >= thresh);
`endif
      end
    end
  end

endmodule

// File: tb/tb_popcount_accumulator.sv
// Directed self-checking bench for popcount_accumulator (IN_SIZE=16, WORDS=4, ACC_SIZE=7).
// Threshold scenario runs only when POPCOUNT_ACC_THRESH_EN is defined.

module tb_popcount_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_count;
`ifdef POPCOUNT_ACC_THRESH_EN
  logic [6:0]  thresh;
  logic        out_above;
`endif

  int checks = 0;
  int errors = 0;

  popcount_accumulator #(
    .IN_SIZE  (16),
    .OUT_SIZE (5),
    .WORDS    (4),
    .ACC_SIZE (7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
`ifdef POPCOUNT_ACC_THRESH_EN
    ,
    .thresh    (thresh),
    .out_above (out_above)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  // Cycles from the last-accept cycle to the first cycle with out_valid high (bounded).
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef POPCOUNT_ACC_THRESH_EN
    thresh = '0;
`endif
    step();
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_count !== 7'd0) begin errors++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    int cyc;
    send(16'h0001); send(16'h0003); send(16'h0007); send(16'hFFFF);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    wait_valid(cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL basic_latency got=%0d exp=2", cyc); end
    checks++; if (out_count !== 7'd22) begin errors++; $display("FAIL basic_count got=%0d exp=22", out_count); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int i = 0; i < 4; i++) send(16'hFFFF);
    wait_valid(cyc);
    checks++; if (out_count !== 7'd64) begin errors++; $display("FAIL full_count got=%0d exp=64", out_count); end
    // Word 0 of the next vector is presented during OUTPUT and taken on the handoff cycle.
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL handoff_in_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < 4; i++) send(16'h0000);
    wait_valid(cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL zero_latency got=%0d exp=2", cyc); end
    checks++; if (out_count !== 7'd0) begin errors++; $display("FAIL zero_count got=%0d exp=0", out_count); end
    step();
  endtask

  task automatic test_backpressure();
    int cyc;
    out_ready = 1'b0;
    send(16'h0001); send(16'h0003); send(16'h0007); send(16'hFFFF);
    wait_valid(cyc);
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_count !== 7'd22 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d got valid=%b count=%0d in_ready=%b exp valid=1 count=22 in_ready=0", i, out_valid, out_count, in_ready);
      end
      step();
    end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h00FF;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid got=%b exp=0", out_valid); end
    send(16'h0001); send(16'h0001); send(16'h0001);
    wait_valid(cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL next_latency got=%0d exp=2", cyc); end
    checks++; if (out_count !== 7'd11) begin errors++; $display("FAIL next_count got=%0d exp=11", out_count); end
    step();
  endtask

  task automatic test_gaps();
    int cyc;
    send(16'h0001); repeat (2) step();
    send(16'h0003); repeat (2) step();
    send(16'h0007); repeat (2) step();
    send(16'hFFFF);
    wait_valid(cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL gap_latency got=%0d exp=2", cyc); end
    checks++; if (out_count !== 7'd22) begin errors++; $display("FAIL gap_count got=%0d exp=22", out_count); end
    step();
  endtask

  task automatic test_mid_reset();
    int cyc;
    send(16'hFFFF); send(16'hFFFF);
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send(16'h0001);
    wait_valid(cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL midrst_latency got=%0d exp=2", cyc); end
    checks++; if (out_count !== 7'd4) begin errors++; $display("FAIL midrst_count got=%0d exp=4", out_count); end
    // Reset while a result is pending must drop it.
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_count !== 7'd0) begin
      errors++; $display("FAIL outrst got valid=%b count=%0d exp valid=0 count=0", out_valid, out_count);
    end
    out_ready = 1'b1;
    step();
  endtask

`ifdef POPCOUNT_ACC_THRESH_EN
  task automatic test_thresh();
    int cyc;
    out_ready = 1'b0;
    thresh = 7'd22;
    send(16'h0001); send(16'h0003); send(16'h0007); send(16'hFFFF);
    wait_valid(cyc);
    checks++; if (out_above !== 1'b1) begin errors++; $display("FAIL above_eq got=%b exp=1", out_above); end
    thresh = 7'h7F;
    step();
    checks++; if (out_above !== 1'b1) begin errors++; $display("FAIL above_hold got=%b exp=1", out_above); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    thresh = 7'd23;
    send(16'h0001); send(16'h0003); send(16'h0007); send(16'hFFFF);
    wait_valid(cyc);
    checks++; if (out_above !== 1'b0) begin errors++; $display("FAIL above_gt got=%b exp=0", out_above); end
    thresh = 7'd0;
    step();
    checks++; if (out_above !== 1'b0) begin errors++; $display("FAIL below_hold got=%b exp=0", out_above); end
    out_ready = 1'b1;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_gaps();
    test_mid_reset();
`ifdef POPCOUNT_ACC_THRESH_EN
    test_thresh();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
